fx3_burst_controller: RTL and testbench
=======================================

# fx3_burst_controller

Read-side sequencer between the ADC sample FIFO/10-to-16-bit conversion stage and the FX3 GPIF bus, all in the FX3 clock domain. Waits until the FIFO reports a full burst available and the FX3 is ready, then issues FIFO read requests for exactly one burst, pausing whenever the FX3 withdraws ready. Generates a data-valid strobe aligned to converted 16-bit words and an end-of-burst marker on the final word.

## Interface
- BURST_WORDS, 8192: words per burst; must not exceed the FIFO's data-available threshold + 1.
- READ_LATENCY, 2: fx3Clk cycles from readData high to the corresponding word on the 16-bit data bus (FIFO q register + conversion register); range 1..4.
- fx3Clk  in  1  sole clock (FX3 GPIF clock); all logic rising-edge.
- nReset  in  1  asynchronous, active-low reset.
- captureEnable  in  1  capture armed; sampled only in IDLE.
- dataAvailable  in  1  FIFO holds at least BURST_WORDS words.
- fx3Ready  in  1  FX3 DMA buffer can accept a word this cycle; synchronous to fx3Clk.
- readData  out  1  FIFO read request (combinational from state, counter, fx3Ready).
- dataValid  out  1  word currently on data bus is valid for FX3.
- endOfBurst  out  1  one-cycle pulse coincident with the last dataValid of a burst.
- burstActive  out  1  high in BURST and DRAIN.
- burstCount  out  16  completed bursts, wraps 16'hFFFF -> 0.

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE: readData=0. Go to BURST when captureEnable && dataAvailable; read counter cleared to 0.
- BURST: readData = fx3Ready. Each cycle with readData=1 increments the read counter (width clog2(BURST_WORDS)). On the read where counter == BURST_WORDS-1: go to DRAIN, latency counter loaded with READ_LATENCY-1.
- fx3Ready low in BURST: readData low, counter holds, state holds; no timeout.
- DRAIN: readData=0; decrement latency counter; at 0 return to IDLE, increment burstCount.
- dataValid: readData delayed READ_LATENCY cycles via shift register (runs in all states).
- endOfBurst: final read tagged; tag delayed identically to dataValid.
- captureEnable falling mid-burst: ignored; burst completes (no partial bursts to host).
- dataAvailable falling mid-burst: ignored (threshold guarantees the words exist).
- Exactly BURST_WORDS dataValid cycles per burst; never more reads than BURST_WORDS.

## Timing
- Reset (async, immediate): state=IDLE, counters 0, shift registers 0; readData, dataValid, endOfBurst, burstActive = 0; burstCount = 0.
- Reset deassertion mid-burst: restart in IDLE; partial burst discarded by host.
- Start: condition true at edge N -> BURST at N+1; first readData high in cycle N+1 if fx3Ready.
- Uninterrupted burst: BURST_WORDS consecutive readData cycles; dataValid same pattern shifted READ_LATENCY cycles.
- After fx3Ready falls, up to READ_LATENCY further dataValid words arrive; FX3 watermark sized accordingly.
- Last read at cycle L: endOfBurst and last dataValid at L+READ_LATENCY; IDLE at L+READ_LATENCY+1 (burstCount updated same edge); burstActive low from then.
- Back-to-back: start condition evaluated in first IDLE cycle; minimum gap between bursts READ_LATENCY+1 cycles with no readData.
- burstActive registered from state; high from BURST entry through last DRAIN cycle.

## Test plan
- Reset: assert nReset low mid-BURST with readData high -> all outputs 0 immediately, burstCount=0, IDLE after release.
- Clean burst (BURST_WORDS=16, READ_LATENCY=2, fx3Ready=1): exactly 16 readData cycles, dataValid 16 cycles starting 2 cycles later, endOfBurst on 16th dataValid only, burstCount 0->1.
- Ready throttling: fx3Ready low on read 5 for 3 cycles and read 15 for 1 cycle -> readData total still 16, counter frozen during gaps, dataValid pattern equals readData delayed 2.
- Arm gating: captureEnable=0, dataAvailable=1 -> no readData for 100 cycles; captureEnable dropped after read 3 -> burst still completes with 16 reads.
- Back-to-back: captureEnable, dataAvailable held high -> reads of successive bursts separated by exactly 3 idle cycles; burstCount increments per burst.
- Wrap: preload burstCount to 16'hFFFF via 65535 short bursts (BURST_WORDS=1) or force -> next completed burst gives 16'h0000.

Source files
------------

// File: rtl/fx3_burst_controller.sv
// fx3_burst_controller
// Read-side sequencer between the ADC sample FIFO / 10-to-16-bit conversion
// stage and the FX3 GPIF bus. Everything runs in the FX3 clock domain.
// It waits for a full burst in the FIFO and an armed capture. It then issues
// exactly BURST_WORDS FIFO reads, pausing while the FX3 withdraws ready.
// It produces a data-valid strobe aligned to the converted words and an
// end-of-burst marker on the final word.
//
// Parameters
//   BURST_WORDS   words per burst (<= FIFO data-available threshold + 1)
//   READ_LATENCY  fx3Clk cycles from readData to word on the bus, 1..4
// Ports
//   fx3Clk         in   sole clock, rising edge
//   nReset         in   asynchronous active-low reset
//   captureEnable  in   capture armed (only looked at in IDLE)
//   dataAvailable  in   FIFO holds at least BURST_WORDS words
//   fx3Ready       in   FX3 can accept a word this cycle
//   readData       out  FIFO read request (combinational)
//   dataValid      out  word on the data bus is valid
//   endOfBurst     out  pulse with the last dataValid of a burst
//   burstActive    out  registered, high in BURST and DRAIN
//   burstCount     out  completed bursts, wraps at 16 bits
//
// state | meaning
// IDLE  | no reads; start when armed and a full burst is available
// BURST | reading while fx3Ready, until BURST_WORDS reads issued
// DRAIN | waiting for the read pipeline to deliver the last words
module fx3_burst_controller #(
    parameter int BURST_WORDS  = 8192,
    parameter int READ_LATENCY = 2
) (
    input  logic        fx3Clk,
    input  logic        nReset,
    input  logic        captureEnable,
    input  logic        dataAvailable,
    input  logic        fx3Ready,
    output logic        readData,
    output logic        dataValid,
    output logic        endOfBurst,
    output logic        burstActive,
    output logic [15:0] burstCount
);

    localparam int CNT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_WORDS - 1);
    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                 state, nextState;
    logic [CNT_W-1:0]       readCount, readCountNext;
    logic [1:0]             latCount, latCountNext;
    logic [15:0]            burstCountQ;
    logic                   countBump;
    logic                   lastRead;
    logic [READ_LATENCY-1:0] validPipe, lastPipe;

    always_comb begin
        nextState     = state;
        readCountNext = readCount;
        latCountNext  = latCount;
        readData      = 1'b0;
        lastRead      = 1'b0;
        countBump     = 1'b0;
        case (state)
            IDLE: begin
                if (captureEnable && dataAvailable) begin
                    nextState     = BURST;
                    readCountNext = '0;
                end
            end
            BURST: begin
                // arming/availability are deliberately ignored here: a burst
                // always completes once started
                readData = fx3Ready;
                if (fx3Ready) begin
                    readCountNext = readCount + CNT_W'(1);
                    if (readCount == LAST_IDX) begin
                        lastRead     = 1'b1;
                        nextState    = DRAIN;
                        latCountNext = LAT_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (latCount == 2'd0) begin
                    nextState = IDLE;
                    countBump = 1'b1;
                end else begin
                    latCountNext = latCount - 2'd1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            readCount   <= '0;
            latCount    <= '0;
            burstCountQ <= '0;
            burstActive <= 1'b0;
        end else begin
            state       <= nextState;
            readCount   <= readCountNext;
            latCount    <= latCountNext;
            burstActive <= (nextState != IDLE);
            if (countBump) begin
                burstCountQ <= burstCountQ + 16'd1;
            end
        end
    end

    // The read strobe and the last-read tag travel down matching delay lines
    // so that dataValid/endOfBurst line up with the converted word.
    always_ff @(posedge fx3Clk or negedge nReset) begin
        if (!nReset) begin
            validPipe <= '0;
            lastPipe  <= '0;
        end else begin
            validPipe[0] <= readData;
            lastPipe[0]  <= lastRead;
            for (int i = 1; i < READ_LATENCY; i++) begin
                validPipe[i] <= validPipe[i-1];
                lastPipe[i]  <= lastPipe[i-1];
            end
        end
    end

    assign dataValid  = validPipe[READ_LATENCY-1];
    assign endOfBurst = lastPipe[READ_LATENCY-1];
    assign burstCount = burstCountQ;

endmodule

// File: tb/tb_fx3_burst_controller.sv
// Testbench for fx3_burst_controller (BURST_WORDS=16, READ_LATENCY=2).
// Stimulus pushes the expected arrival cycle and end-of-burst flag of every
// read into a queue; a monitor pops and compares whenever dataValid is high.
module tb_fx3_burst_controller;

    logic        fx3Clk;
    logic        nReset;
    logic        captureEnable;
    logic        dataAvailable;
    logic        fx3Ready;
    logic        readData;
    logic        dataValid;
    logic        endOfBurst;
    logic        burstActive;
    logic [15:0] burstCount;

    fx3_burst_controller #(
        .BURST_WORDS (16),
        .READ_LATENCY(2)
    ) dut (
        .fx3Clk       (fx3Clk),
        .nReset       (nReset),
        .captureEnable(captureEnable),
        .dataAvailable(dataAvailable),
        .fx3Ready     (fx3Ready),
        .readData     (readData),
        .dataValid    (dataValid),
        .endOfBurst   (endOfBurst),
        .burstActive  (burstActive),
        .burstCount   (burstCount)
    );

    typedef struct {
        int cycle;
        bit eob;
    } expT;

    expT q[$];
    expT monE;
    expT pushE;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  monOn = 1'b0;

    initial begin
        fx3Clk = 1'b0;
        forever #5 fx3Clk = ~fx3Clk;
    end

    always @(posedge fx3Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor
    always @(negedge fx3Clk) begin
        if (monOn && nReset) begin
            if (dataValid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpectedValid: got dataValid=1 expected no pending word (cycle %0d)", cyc);
                end else begin
                    monE = q.pop_front();
                    chk("dataValidCycle", cyc, monE.cycle);
                    chk("endOfBurst", {31'd0, endOfBurst}, {31'd0, monE.eob});
                end
            end else if (endOfBurst) begin
                checks++;
                errors++;
                $display("FAIL strayEndOfBurst: got endOfBurst=1 dataValid=0 expected 0 (cycle %0d)", cyc);
            end
        end
    end

    // IDLE cycle with the start condition presented
    task automatic startIdle();
        @(negedge fx3Clk);
        captureEnable = 1'b1;
        dataAvailable = 1'b1;
        fx3Ready      = 1'b1;
        #1;
        chk("startIdleRead", {31'd0, readData}, 32'd0);
        chk("startIdleActive", {31'd0, burstActive}, 32'd0);
    endtask

    // One burst, starting in the first BURST cycle. fx3Ready is pulled low
    // for gNLen cycles when gNAt reads have been issued (-1 = no gap).
    task automatic burstBody(input int g1At, input int g1Len, input int g2At, input int g2Len,
                             input bit dropArmAt3, input bit keepArmed,
                             input logic [15:0] expCount);
        int reads  = 0;
        int g1Left = g1Len;
        int g2Left = g2Len;
        bit rdy;
        while (reads < 16) begin
            @(negedge fx3Clk);
            if (reads == g1At && g1Left > 0) begin
                rdy = 1'b0;
                g1Left--;
            end else if (reads == g2At && g2Left > 0) begin
                rdy = 1'b0;
                g2Left--;
            end else begin
                rdy = 1'b1;
            end
            fx3Ready = rdy;
            if (dropArmAt3 && reads == 3) begin
                captureEnable = 1'b0;
                dataAvailable = 1'b0;
            end
            #1;
            chk("burstRead", {31'd0, readData}, {31'd0, rdy});
            chk("burstActive", {31'd0, burstActive}, 32'd1);
            if (rdy) begin
                pushE.cycle = cyc + 2;
                pushE.eob   = (reads == 15);
                q.push_back(pushE);
                reads++;
            end
        end
        // DRAIN: fx3Ready high must not produce reads
        @(negedge fx3Clk);
        fx3Ready = 1'b1;
        #1;
        chk("drainRead1", {31'd0, readData}, 32'd0);
        chk("drainActive1", {31'd0, burstActive}, 32'd1);
        @(negedge fx3Clk);
        #1;
        chk("drainRead2", {31'd0, readData}, 32'd0);
        chk("drainActive2", {31'd0, burstActive}, 32'd1);
        // first IDLE cycle
        @(negedge fx3Clk);
        if (!keepArmed) captureEnable = 1'b0;
        #1;
        chk("idleRead", {31'd0, readData}, 32'd0);
        chk("idleActive", {31'd0, burstActive}, 32'd0);
        chk("burstCount", {16'd0, burstCount}, {16'd0, expCount});
        chk("pendingWords", q.size(), 32'd0);
    endtask

    int idleReads;

    initial begin
        nReset        = 1'b0;
        captureEnable = 1'b0;
        dataAvailable = 1'b0;
        fx3Ready      = 1'b0;
        repeat (3) @(negedge fx3Clk);
        #1;
        chk("rstRead", {31'd0, readData}, 32'd0);
        chk("rstValid", {31'd0, dataValid}, 32'd0);
        chk("rstEob", {31'd0, endOfBurst}, 32'd0);
        chk("rstActive", {31'd0, burstActive}, 32'd0);
        chk("rstCount", {16'd0, burstCount}, 32'd0);
        nReset = 1'b1;
        monOn  = 1'b1;

        // arm gating: not armed, then armed without data
        @(negedge fx3Clk);
        captureEnable = 1'b0;
        dataAvailable = 1'b1;
        fx3Ready      = 1'b1;
        idleReads     = 0;
        repeat (100) begin
            @(negedge fx3Clk);
            #1;
            if (readData || burstActive) idleReads++;
        end
        captureEnable = 1'b1;
        dataAvailable = 1'b0;
        repeat (20) begin
            @(negedge fx3Clk);
            #1;
            if (readData || burstActive) idleReads++;
        end
        chk("unarmedActivity", idleReads, 32'd0);

        // clean burst
        startIdle();
        burstBody(-1, 0, -1, 0, 1'b0, 1'b0, 16'd1);

        // ready throttling: 3-cycle gap before read 5, 1-cycle gap before read 15
        startIdle();
        burstBody(4, 3, 14, 1, 1'b0, 1'b0, 16'd2);

        // capture disarmed (and data flag dropped) after read 3
        startIdle();
        burstBody(-1, 0, -1, 0, 1'b1, 1'b0, 16'd3);

        // back-to-back: exactly 3 non-read cycles between bursts
        startIdle();
        burstBody(-1, 0, -1, 0, 1'b0, 1'b1, 16'd4);
        burstBody(-1, 0, -1, 0, 1'b0, 1'b1, 16'd5);
        burstBody(2, 2, -1, 0, 1'b0, 1'b0, 16'd6);

        // reset mid-burst with readData high
        monOn = 1'b0;
        startIdle();
        repeat (6) @(negedge fx3Clk);
        #1;
        chk("midBurstRead", {31'd0, readData}, 32'd1);
        nReset = 1'b0;
        #1;
        chk("asyncRstRead", {31'd0, readData}, 32'd0);
        chk("asyncRstValid", {31'd0, dataValid}, 32'd0);
        chk("asyncRstEob", {31'd0, endOfBurst}, 32'd0);
        chk("asyncRstActive", {31'd0, burstActive}, 32'd0);
        chk("asyncRstCount", {16'd0, burstCount}, 32'd0);
        captureEnable = 1'b0;
        repeat (2) @(negedge fx3Clk);
        nReset = 1'b1;
        repeat (3) @(negedge fx3Clk);
        #1;
        chk("postRstRead", {31'd0, readData}, 32'd0);
        chk("postRstActive", {31'd0, burstActive}, 32'd0);
        chk("postRstValid", {31'd0, dataValid}, 32'd0);
        q.delete();
        monOn = 1'b1;

        // wrap: preload counter to FFFF, next burst gives 0000
        @(negedge fx3Clk);
        force dut.burstCountQ = 16'hFFFF;
        @(posedge fx3Clk);
        @(negedge fx3Clk);
        release dut.burstCountQ;
        #1;
        chk("preloadCount", {16'd0, burstCount}, 32'h0000FFFF);
        startIdle();
        burstBody(-1, 0, -1, 0, 1'b0, 1'b0, 16'h0000);

        repeat (5) @(negedge fx3Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
